// File: rtl/snp_pair_drain.sv
// Drains the candidate-SNP-pair result FIFO after the boost engine finishes,
// packing pairs into wide beats for host writeback, then pulses clear_done.
module snp_pair_drain #(
    parameter  int PE_WIDTH  = 16,
    parameter  int OUT_WIDTH = 512,
    localparam int PPB       = OUT_WIDTH / (2 * PE_WIDTH),
    localparam int CW        = $clog2(PPB) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boost_done,
    input  logic [PE_WIDTH-1:0]   snp_pair_num,
    output logic                  snp_pair_rd_en,
    input  logic [2*PE_WIDTH-1:0] snp_pair_in,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CW-1:0]         out_pairs,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  clear_done,
    output logic                  busy
);

    localparam int PW = 2 * PE_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, SEND, CLEAR} state_t;

    state_t               state_q;
    logic [PE_WIDTH-1:0]  remaining_q;
    logic [CW-1:0]        target_q;
    logic [CW-1:0]        issued_q;
    logic [CW-1:0]        captured_q;
    logic                 cap_q;
    logic                 rd_en_q;
    logic [OUT_WIDTH-1:0] beat_q;
    logic [CW-1:0]        out_pairs_q;
    logic                 out_last_q;
    logic                 out_valid_q;
    logic                 clear_q;
    logic [CW-1:0]        target_d;

    function automatic logic [CW-1:0] next_target(input logic [PE_WIDTH-1:0] rem);
        if (rem >= PE_WIDTH'(PPB)) return CW'(PPB);
        else                       return rem[CW-1:0];
    endfunction

    // In IDLE the pair count comes straight from the port; afterwards from the latched remainder.
    assign target_d = (state_q == IDLE) ? next_target(snp_pair_num) : next_target(remaining_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            target_q    <= '0;
            issued_q    <= '0;
            captured_q  <= '0;
            cap_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            beat_q      <= '0;
            out_pairs_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            cap_q <= rd_en_q;
            case (state_q)
                IDLE: begin
                    if (boost_done) begin
                        remaining_q <= snp_pair_num;
                        if (snp_pair_num == '0) begin
                            state_q <= CLEAR;
                            clear_q <= 1'b1;
                        end else begin
                            state_q    <= FILL;
                            target_q   <= target_d;
                            issued_q   <= CW'(1);
                            captured_q <= '0;
                            rd_en_q    <= 1'b1;
                            beat_q     <= '0;
                        end
                    end
                end
                FILL: begin
                    if (issued_q < target_q) begin
                        rd_en_q  <= 1'b1;
                        issued_q <= issued_q + CW'(1);
                    end else begin
                        rd_en_q <= 1'b0;
                    end
                    // Read data trails the strobe by one cycle, so capture follows cap_q.
                    if (cap_q) begin
                        for (int s = 0; s < PPB; s++) begin
                            if (captured_q == CW'(s)) beat_q[s*PW +: PW] <= snp_pair_in;
                        end
                        captured_q <= captured_q + CW'(1);
                        if (captured_q + CW'(1) == target_q) begin
                            state_q     <= SEND;
                            out_valid_q <= 1'b1;
                            out_pairs_q <= target_q;
                            out_last_q  <= (remaining_q == PE_WIDTH'(target_q));
                            remaining_q <= remaining_q - PE_WIDTH'(target_q);
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q <= CLEAR;
                            clear_q <= 1'b1;
                        end else begin
                            state_q    <= FILL;
                            target_q   <= target_d;
                            issued_q   <= CW'(1);
                            captured_q <= '0;
                            rd_en_q    <= 1'b1;
                            beat_q     <= '0;
                        end
                    end
                end
                CLEAR: begin
                    clear_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign snp_pair_rd_en = rd_en_q;
    assign out_data       = beat_q;
    assign out_pairs      = out_pairs_q;
    assign out_last       = out_last_q;
    assign out_valid      = out_valid_q;
    assign clear_done     = clear_q;
    assign busy           = (state_q != IDLE);

endmodule
